// File: rtl/b8_pkg.sv
// Shared types and constants for the bit-serial subtractor slice.
// Holds the FSM state encoding and the default operand width.
package b8_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sub_state_t;

    localparam int B8_WIDTH = 8;

endpackage

// File: rtl/b8_serial_sub_if.sv
// Start/done request bus between a requester and the serial subtractor.
// The requester drives operands and start; the subtractor returns the result and status.
interface b8_serial_sub_if #(
    parameter int WIDTH = 8
);

    logic             start;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             bin;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;
    logic             busy;
    logic             done;

    modport master (
        output start, x, y, bin,
        input  diff, bout, ovf, busy, done
    );

    modport slave (
        input  start, x, y, bin,
        output diff, bout, ovf, busy, done
    );

endinterface

// File: rtl/b8_serial_sub_fs1.sv
// Combinational one-bit full subtractor: d = a - b - bin, with the borrow
// raised whenever the column has to take from the next more significant bit.
module fs1 (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/b8_serial_sub.sv
// Bit-serial subtractor computing x - y - bin one bit per clock, LSB first,
// through a single full-subtractor cell and a registered borrow.
module b8_serial_sub
    import b8_pkg::*;
#(
    parameter int WIDTH = B8_WIDTH
) (
    input  logic               clk,
    input  logic               reset,
    b8_serial_sub_if.slave     bus
);

    localparam int              CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

    sub_state_t       r_state;
    sub_state_t       w_stateNext;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_xShift;
    logic [WIDTH-1:0] r_yShift;
    logic [WIDTH-1:0] r_diff;
    logic             r_borrow;
    logic             r_bout;
    logic             r_ovf;
    logic             w_accept;
    logic             w_lastStep;
    logic             w_diffBit;
    logic             w_borrowNext;

    fs1 u_fs1 (
        .a    (r_xShift[0]),
        .b    (r_yShift[0]),
        .bin  (r_borrow),
        .d    (w_diffBit),
        .bout (w_borrowNext)
    );

    assign w_accept   = (r_state == IDLE) && bus.start;
    assign w_lastStep = (r_state == RUN) && (r_count == LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        unique case (r_state)
            IDLE:    if (bus.start) w_stateNext = RUN;
            RUN:     if (r_count == LAST) w_stateNext = DONE;
            DONE:    w_stateNext = IDLE;
            default: w_stateNext = IDLE;
        endcase
    end

    // The borrow held in r_borrow during the final step is the borrow into the MSB,
    // so signed overflow falls out of it and the outgoing borrow with no extra register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count  <= '0;
            r_xShift <= '0;
            r_yShift <= '0;
            r_diff   <= '0;
            r_borrow <= 1'b0;
            r_bout   <= 1'b0;
            r_ovf    <= 1'b0;
        end else if (w_accept) begin
            r_count  <= '0;
            r_xShift <= bus.x;
            r_yShift <= bus.y;
            r_borrow <= bus.bin;
        end else if (r_state == RUN) begin
            r_count  <= r_count + 1'b1;
            r_xShift <= r_xShift >> 1;
            r_yShift <= r_yShift >> 1;
            r_diff   <= {w_diffBit, r_diff[WIDTH-1:1]};
            r_borrow <= w_borrowNext;
            if (w_lastStep) begin
                r_bout <= w_borrowNext;
                r_ovf  <= r_borrow ^ w_borrowNext;
            end
        end
    end

    assign bus.diff = r_diff;
    assign bus.bout = r_bout;
    assign bus.ovf  = r_ovf;
    assign bus.busy = (r_state != IDLE);
    assign bus.done = (r_state == DONE);

endmodule

// File: tb/tb_b8_serial_sub.sv
// Directed and swept checks of the serial subtractor at WIDTH=8, plus an
// exhaustive pass over a WIDTH=4 instance, against an arithmetic reference.
module tb_b8_serial_sub;

    logic clk = 1'b0;
    logic reset;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    b8_serial_sub_if #(.WIDTH(8)) bus8 ();
    b8_serial_sub_if #(.WIDTH(4)) bus4 ();

    b8_serial_sub #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus8.slave)
    );

    b8_serial_sub #(.WIDTH(4)) dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus4.slave)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic waitEdge();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [7:0] x, input logic [7:0] y, input logic b);
        bus8.x     = x;
        bus8.y     = y;
        bus8.bin   = b;
        bus8.start = 1'b1;
        waitEdge();
        bus8.start = 1'b0;
    endtask

    // Checks an 8-bit result against {bout,diff} = {0,x}-y-bin and the signed range.
    task automatic checkResult8(input string tag, input logic [7:0] x, input logic [7:0] y, input logic b);
        logic [8:0] full;
        logic [7:0] back;
        int         s;
        full = {1'b0, x} - {1'b0, y} - {8'b0, b};
        s    = int'($signed(x)) - int'($signed(y)) - int'(b);
        back = bus8.diff + y + {7'b0, b};
        checkOutput({tag, " diff"}, 32'(bus8.diff), 32'(full[7:0]));
        checkOutput({tag, " bout"}, 32'(bus8.bout), 32'(full[8]));
        checkOutput({tag, " ovf"}, 32'(bus8.ovf), 32'((s < -128) || (s > 127)));
        checkOutput({tag, " roundtrip"}, 32'(back), 32'(x));
    endtask

    task automatic runOp8(input string tag, input logic [7:0] x, input logic [7:0] y, input logic b);
        int edges;
        applyStimulus(x, y, b);
        checkOutput({tag, " busy"}, 32'(bus8.busy), 32'd1);
        edges = 0;
        while (!bus8.done && edges < 20) begin
            waitEdge();
            edges++;
        end
        checkOutput({tag, " latency"}, 32'(edges), 32'd8);
        checkResult8(tag, x, y, b);
        waitEdge();
        checkOutput({tag, " idle"}, 32'({bus8.busy, bus8.done}), 32'd0);
    endtask

    task automatic runOp4(input logic [3:0] x, input logic [3:0] y, input logic b);
        int         edges;
        int         s;
        logic [4:0] full;
        bus4.x     = x;
        bus4.y     = y;
        bus4.bin   = b;
        bus4.start = 1'b1;
        waitEdge();
        bus4.start = 1'b0;
        edges = 0;
        while (!bus4.done && edges < 12) begin
            waitEdge();
            edges++;
        end
        full = {1'b0, x} - {1'b0, y} - {4'b0, b};
        s    = int'($signed(x)) - int'($signed(y)) - int'(b);
        checkOutput("w4 latency", 32'(edges), 32'd4);
        checkOutput("w4 diffbout", 32'({bus4.bout, bus4.diff}), 32'(full));
        checkOutput("w4 ovf", 32'(bus4.ovf), 32'((s < -8) || (s > 7)));
        waitEdge();
    endtask

    initial begin
        logic [7:0] rx;
        logic [7:0] ry;
        logic       rb;
        int         edges;

        reset      = 1'b1;
        bus8.start = 1'b0;
        bus8.x     = '0;
        bus8.y     = '0;
        bus8.bin   = 1'b0;
        bus4.start = 1'b0;
        bus4.x     = '0;
        bus4.y     = '0;
        bus4.bin   = 1'b0;
        waitEdge();
        waitEdge();
        checkOutput("reset outputs", 32'({bus8.diff, bus8.bout, bus8.ovf, bus8.busy, bus8.done}), 32'd0);
        reset = 1'b0;
        waitEdge();

        runOp8("a", 8'h00, 8'hAA, 1'b1);
        checkOutput("a diff const", 32'(bus8.diff), 32'h55);
        runOp8("c", 8'h80, 8'h01, 1'b0);
        checkOutput("c ovf const", 32'({bus8.diff, bus8.bout, bus8.ovf}), 32'({8'h7F, 1'b0, 1'b1}));
        runOp8("d", 8'h97, 8'h84, 1'b0);
        checkOutput("d diff const", 32'(bus8.diff), 32'h13);
        runOp8("yff", 8'h3C, 8'hFF, 1'b1);
        checkOutput("yff const", 32'({bus8.diff, bus8.bout}), 32'({8'h3C, 1'b1}));

        // Start held high: done should land every 10 edges.
        bus8.x     = 8'h52;
        bus8.y     = 8'h3A;
        bus8.bin   = 1'b0;
        bus8.start = 1'b1;
        waitEdge();
        for (int k = 1; k <= 28; k++) begin
            waitEdge();
            checkOutput($sformatf("b2b done@%0d", k), 32'(bus8.done), 32'((k == 8) || (k == 18) || (k == 28)));
            if (k == 8) begin
                checkOutput("b2b result", 32'({bus8.diff, bus8.bout, bus8.ovf}), 32'({8'h18, 1'b0, 1'b0}));
            end
        end
        bus8.start = 1'b0;
        waitEdge();

        // Second start during RUN must be ignored.
        applyStimulus(8'h49, 8'h70, 1'b1);
        waitEdge();
        waitEdge();
        bus8.x     = 8'hFF;
        bus8.start = 1'b1;
        waitEdge();
        bus8.start = 1'b0;
        edges = 3;
        while (!bus8.done && edges < 20) begin
            waitEdge();
            edges++;
        end
        checkOutput("ign latency", 32'(edges), 32'd8);
        checkOutput("ign result", 32'({bus8.diff, bus8.bout, bus8.ovf}), 32'({8'hD8, 1'b1, 1'b0}));
        waitEdge();
        waitEdge();
        checkOutput("ign no requeue", 32'({bus8.busy, bus8.done}), 32'd0);

        // Asynchronous reset in the 4th RUN cycle.
        applyStimulus(8'hC3, 8'h21, 1'b0);
        waitEdge();
        waitEdge();
        waitEdge();
        #2 reset = 1'b1;
        #1 checkOutput("async reset", 32'({bus8.diff, bus8.bout, bus8.ovf, bus8.busy, bus8.done}), 32'd0);
        waitEdge();
        #2 reset = 1'b0;
        edges = 0;
        for (int k = 0; k < 12; k++) begin
            waitEdge();
            if (bus8.done || bus8.busy) edges++;
        end
        checkOutput("no done after reset", 32'(edges), 32'd0);
        runOp8("e", 8'h05, 8'h05, 1'b0);
        checkOutput("e const", 32'({bus8.diff, bus8.bout}), 32'd0);

        for (int n = 0; n < 1000; n++) begin
            rx = 8'($urandom);
            ry = 8'($urandom);
            rb = 1'($urandom);
            runOp8("rnd", rx, ry, rb);
        end

        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                for (int c = 0; c < 2; c++) begin
                    runOp4(4'(a), 4'(b), 1'(c));
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
